// File: rtl/spi_wb_sequencer.sv
// Wishbone master that runs the SS/TX/CTRL/poll/RX register sequence on an SPI master core
// for each valid/ready command. Define SPI_SEQ_IRQ_EN to wait on spi_int_i instead of polling CTRL.
module spi_wb_sequencer #(
  parameter logic [31:0] DIVIDER  = 32'd4,
  parameter int          POLL_GAP = 4,
  parameter int          ACK_TO   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_data_i,
  input  logic [4:0]  cmd_len_i,
  input  logic [31:0] cmd_ss_i,
  input  logic [3:0]  cmd_mode_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [4:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        spi_int_i
);

  localparam logic [4:0] ADR_TXRX = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  typedef enum logic [2:0] {INIT, IDLE, WR_SS, WR_TX, WR_GO, WAIT, RD_RX, RSP} state_t;

  state_t      state;
  logic [31:0] data_q;
  logic [31:0] ss_q;
  logic [4:0]  len_q;
  logic [3:0]  mode_q;
  logic [31:0] to_cnt;
  logic        init_abort;
  logic        ie;

  logic [4:0]  acc_adr;
  logic [31:0] acc_dat;
  logic [3:0]  acc_sel;
  logic        acc_we;

`ifdef SPI_SEQ_IRQ_EN
  assign ie = 1'b1;
`else
  logic [31:0] gap_cnt;
  logic        unused_spi_int;
  assign ie = 1'b0;
  assign unused_spi_int = spi_int_i;
`endif

  // Bus access that the current state would issue; CTRL is only ever touched on its low two bytes.
  always_comb begin
    acc_adr = ADR_TXRX;
    acc_dat = '0;
    acc_sel = 4'b1111;
    acc_we  = 1'b1;
    case (state)
      INIT: begin
        acc_adr = ADR_DIV;
        acc_dat = DIVIDER;
      end
      WR_SS: begin
        acc_adr = ADR_SS;
        acc_dat = ss_q;
      end
      WR_TX: acc_dat = data_q;
      WR_GO: begin
        acc_adr = ADR_CTRL;
        acc_sel = 4'b0011;
        acc_dat = {18'b0, mode_q[3], ie, mode_q[2], mode_q[1], mode_q[0],
                   1'b1, 1'b0, 2'b00, len_q};
      end
      WAIT: begin
        acc_adr = ADR_CTRL;
        acc_sel = 4'b0011;
        acc_we  = 1'b0;
      end
      RD_RX: acc_we = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= INIT;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      data_q      <= '0;
      ss_q        <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      to_cnt      <= '0;
      init_abort  <= 1'b0;
`ifndef SPI_SEQ_IRQ_EN
      gap_cnt     <= '0;
`endif
    end else if (wbm_cyc_o) begin
      // Cycle in flight: finish on ack, or abandon it once the ack budget runs out.
      if (wbm_ack_i) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        case (state)
          INIT: begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
          WR_SS: state <= WR_TX;
          WR_TX: state <= WR_GO;
          WR_GO: state <= WAIT;
`ifndef SPI_SEQ_IRQ_EN
          WAIT: if (!wbm_dat_i[8]) state <= RD_RX;
`endif
          RD_RX: begin
            rsp_data_o  <= wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end
          default: ;
        endcase
      end else if ((ACK_TO != 0) && (to_cnt == 32'(ACK_TO - 1))) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_err_o   <= 1'b1;
        rsp_data_o  <= '0;
        rsp_valid_o <= 1'b1;
        init_abort  <= (state == INIT);
        busy_o      <= 1'b1;
        state       <= RSP;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            data_q      <= cmd_data_i;
            ss_q        <= cmd_ss_i;
            len_q       <= cmd_len_i;
            mode_q      <= cmd_mode_i;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= WR_SS;
          end
        end
        WAIT: begin
`ifdef SPI_SEQ_IRQ_EN
          if (spi_int_i) state <= RD_RX;
`else
          if (gap_cnt == 32'(POLL_GAP)) begin
            gap_cnt   <= '0;
            to_cnt    <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_adr_o <= acc_adr;
            wbm_dat_o <= acc_dat;
            wbm_sel_o <= acc_sel;
            wbm_we_o  <= acc_we;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
`endif
        end
        RSP: begin
          // An aborted DIVIDER write must be retried, so that error returns to INIT.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            if (init_abort) begin
              init_abort <= 1'b0;
              state      <= INIT;
            end else begin
              cmd_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          busy_o    <= 1'b1;
          to_cnt    <= '0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_adr_o <= acc_adr;
          wbm_dat_o <= acc_dat;
          wbm_sel_o <= acc_sel;
          wbm_we_o  <= acc_we;
        end
      endcase
    end
  end

endmodule
